// File: rtl/slot_sched_pkg.sv
// slot_sched_pkg: shared state type, defaults and slot index type for slot schedulers
package slot_sched_pkg;
  localparam int N_SLOTS_DEF = 10;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RELEASE} sched_state_e;
  typedef logic [$clog2(N_SLOTS_DEF)-1:0] slot_idx_t;
endpackage

// File: rtl/slot_rr_scheduler_rr_pick.sv
// rr_pick: rotating priority encoder, first set req bit after last_i with wrap
module rr_pick #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  int j;
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    j = 0;
    // walk farthest to nearest so the slot right after last_i wins
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) idx_o = W'(j);
    end
  end
endmodule

// File: rtl/slot_rr_scheduler.sv
// slot_rr_scheduler: round-robin owner of one shared resource with start pulse and watchdog
module slot_rr_scheduler
  import slot_sched_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W = $clog2(N_SLOTS),
  localparam int CNT_W = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SLOTS-1:0] req,
  input  logic               done,
  output logic [N_SLOTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               start,
  output logic               busy,
  output logic               timeout_err,
  output logic [IDX_W-1:0]   err_idx
);
  sched_state_e       state_q;
  logic [N_SLOTS-1:0] grant_q;
  logic [IDX_W-1:0]   idx_q, last_q, err_q, pick_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic               start_q, busy_q, pick_valid, tmo_hit;
  rr_pick #(.N(N_SLOTS), .W(IDX_W)) u_pick (
    .req_i(req), .last_i(last_q), .valid_o(pick_valid), .idx_o(pick_idx)
  );
  // done in the final watchdog cycle suppresses the error
  assign tmo_hit = !rst && state_q == WAIT && !done && cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_SLOTS - 1);
      err_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_valid) begin
          grant_q <= {{(N_SLOTS-1){1'b0}}, 1'b1} << pick_idx;
          idx_q   <= pick_idx;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= GRANT;
        end
        GRANT: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (done || tmo_hit) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end
          if (tmo_hit) err_q <= idx_q;
        end
        RELEASE: begin
          last_q  <= idx_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_hit;
  assign err_idx     = err_q;
endmodule

// File: doc/slot_rr_scheduler.md
# slot_rr_scheduler

Round-robin scheduler that shares one execution resource among the ten child slot instances of a generated hierarchy level. It arbitrates the slot request lines, issues a one-cycle start pulse to the winner, and holds the grant until the resource reports done or a watchdog expires. It sits beside the slot instances in the parent level, and the parent gates each slot's access with the one-hot grant.

## Interface
- N_SLOTS, 10, number of requesting slots (2..64)
- TIMEOUT, 255, maximum WAIT cycles before forced release (≥2)
- IDX_W, $clog2(N_SLOTS), width of slot index (derived, not overridden)

- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_SLOTS  level request per slot
- done  in  1  resource completion pulse for the current grant
- grant  out  N_SLOTS  one-hot grant, all-zero when idle
- grant_idx  out  IDX_W  index of granted slot; holds last value when idle
- start  out  1  one-cycle pulse to resource at grant begin
- busy  out  1  high from GRANT through RELEASE
- timeout_err  out  1  one-cycle pulse on watchdog release
- err_idx  out  IDX_W  slot index of last timeout, held until next timeout

## Operation
- FSM states: IDLE, GRANT, WAIT, RELEASE.
- IDLE: if any req bit set, pick the first set bit searching from (last_idx+1) mod N_SLOTS upward with wrap; register grant/grant_idx; go GRANT. Else stay.
- GRANT: start=1 for exactly this cycle; clear watchdog counter; go WAIT.
- WAIT: counter increments each cycle. done=1 -> go RELEASE. If counter reaches TIMEOUT-1 with done=0 -> timeout_err=1, err_idx=grant_idx, go RELEASE. done and timeout in the same cycle: done wins, no error.
- RELEASE: grant cleared, last_idx=grant_idx, go IDLE. One-cycle bubble guarantees the resource sees grant drop between owners.
- done outside WAIT is ignored (no state change, no error).
- req deassertion by the granted slot while granted is ignored; grant is held until done/timeout.
- Arbitration uses req values sampled in IDLE only; changes during GRANT/WAIT/RELEASE have no effect on the current grant.
- Watchdog counter width: $clog2(TIMEOUT); saturates, never wraps.

## Timing
- Reset values: grant=0, grant_idx=0, start=0, busy=0, timeout_err=0, err_idx=0, state=IDLE, last_idx=N_SLOTS-1 (slot 0 has first priority after reset), counter=0.
- req high at edge k (in IDLE) -> grant/busy high from edge k+1, start high cycle k+1 only.
- done sampled in WAIT at edge m -> grant=0 from edge m+1 (RELEASE), next grant at earliest edge m+2 via IDLE -> GRANT at m+3.
- Minimum occupancy per grant: 4 cycles (IDLE, GRANT, WAIT, RELEASE).
- Timeout: with no done, timeout_err pulses in the TIMEOUT-th WAIT cycle; grant drops on the following edge.
- rst asserted in any state: all registers return to reset values on that edge; start and timeout_err never complete a pulse across reset.

## Structure
- Shared package slot_sched_pkg: state enum typedef (sched_state_e), default N_SLOTS/TIMEOUT localparams, slot index type.
- Sub-module rr_pick: combinational rotate-priority-encode (req, last_idx -> valid, idx); reusable by other hierarchy levels. FSM, counter and output registers in the top.

## Test plan
- Reset then req=10'b0000000001 -> grant=0x001, grant_idx=0, start pulse one cycle after req, busy high; done after 3 WAIT cycles -> grant=0 next edge.
- req=10'b1111111111 held, done 2 cycles after each start -> grant_idx sequence 0,1,2,...,9,0 with exactly one RELEASE bubble between grants.
- Last grant idx 9, req=10'b1000000001 -> next grant_idx=0 (wrap); then next grant_idx=9.
- TIMEOUT=8, slot 3 granted, done never -> timeout_err pulse in 8th WAIT cycle, err_idx=3, grant drops next edge, slot 4 request then served.
- done and timeout same cycle (done in 8th WAIT cycle, TIMEOUT=8) -> timeout_err=0, normal release; done pulse in IDLE -> no state change.
- rst high during WAIT for slot 5 -> next edge all outputs zero, state IDLE; with req=all ones afterwards -> grant_idx=0 first.
